// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared definitions for the parametrised HUB75 BCM scanner:
//   - state_t   : scan FSM states (SHIFT, LATCH, SETTLE, DISPLAY)
//   - IDX_*     : bit positions of each colour inside rd_data
//                 rd_data = {R1,G1,B1,R2,G2,B2}
// ---------------------------------------------------------------------------
package hub75_pkg;

   typedef enum logic [1:0] {
      S_SHIFT   = 2'd0,
      S_LATCH   = 2'd1,
      S_SETTLE  = 2'd2,
      S_DISPLAY = 2'd3
   } state_t;

   localparam int unsigned IDX_R1 = 5;
   localparam int unsigned IDX_G1 = 4;
   localparam int unsigned IDX_B1 = 3;
   localparam int unsigned IDX_R2 = 2;
   localparam int unsigned IDX_G2 = 1;
   localparam int unsigned IDX_B2 = 0;

endpackage

// File: rtl/hub75_bcm_timer.sv
// ---------------------------------------------------------------------------
// hub75_bcm_timer
// Display-phase timer for one BCM bit plane. Loaded once per plane (at LATCH)
// with the plane length BASE_UNIT<<plane and the brightness-scaled on-time;
// counts while i_run is high.
// Ports:
//   clk_in, rst_n   : clock, async active-low reset
//   i_load          : capture plane length and on-time (LATCH cycle)
//   i_run           : count one display cycle (DISPLAY state)
//   i_plane         : current bit plane index
//   i_brightness    : global dimming, 255 = full
//   o_oe_n          : panel output enable (active low), low for on-time only
//   o_plane_done    : high in the final display cycle of the plane
// ---------------------------------------------------------------------------
module hub75_bcm_timer #(
   parameter int unsigned BASE_UNIT  = 64,
   parameter int unsigned COLOR_BITS = 4,
   parameter int unsigned PW         = 2
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_run,
   input  logic [PW-1:0] i_plane,
   input  logic [7:0]    i_brightness,
   output logic          o_oe_n,
   output logic          o_plane_done
);

   // Width covers the longest plane, BASE_UNIT<<(COLOR_BITS-1), inclusive.
   localparam int unsigned TW     = $clog2(BASE_UNIT << (COLOR_BITS - 1)) + 1;
   localparam int unsigned PROD_W = TW + 9;

   logic [TW-1:0]     r_len;
   logic [TW-1:0]     r_on;
   logic [TW-1:0]     r_cnt;
   logic [TW-1:0]     w_len;
   logic [PROD_W-1:0] w_prod;
   logic [PROD_W-1:0] w_on_full;

   // Full-width product before the >>8 so the on-time is never truncated;
   // the result is at most w_len and therefore fits TW bits.
   always_comb begin
      w_len     = TW'(BASE_UNIT) << i_plane;
      w_prod    = PROD_W'(w_len) * PROD_W'({1'b0, i_brightness} + 9'd1);
      w_on_full = w_prod >> 8;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_len <= '0;
         r_on  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_len <= w_len;
         r_on  <= w_on_full[TW-1:0];
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

   assign o_oe_n       = !(i_run && (r_cnt < r_on));
   assign o_plane_done = i_run && (r_cnt == (r_len - TW'(1)));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// ---------------------------------------------------------------------------
// hub75_bcm_scanner
// Parametrised HUB75 panel scanner with binary-coded modulation. Reads plane
// bits from an external pixel store (1-cycle read latency), shifts one row
// pair per plane, latches it, then displays it for BASE_UNIT<<plane cycles
// with OE duty scaled by global brightness. Buffer swaps happen only at the
// frame boundary.
// Optional feature: define HUB75_DEADTIME_EN to insert DEADTIME settle cycles
// (OE=1, LAT=0) between LATCH and DISPLAY.
// Ports:
//   clk_in, rst_n            : clock, async active-low reset
//   brightness               : global dimming, sampled at LATCH
//   swap_req / swap_ack      : level request, 1-cycle ack at frame end
//   frame_done               : 1-cycle pulse after the last plane of last row
//   rd_col/rd_row/rd_plane   : pixel-store read address
//   rd_buf                   : active buffer
//   rd_data                  : {R1,G1,B1,R2,G2,B2}, valid 1 cycle after address
//   row_sel                  : panel row address
//   R1,G1,B1,R2,G2,B2        : panel colour data
//   CLK, LAT, OE             : panel shift clock, latch, output enable (low)
// ---------------------------------------------------------------------------
module hub75_bcm_scanner
   import hub75_pkg::*;
#(
   parameter int unsigned PANEL_W    = 64,
   parameter int unsigned SCAN_ROWS  = 32,
   parameter int unsigned COLOR_BITS = 4,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned BASE_UNIT  = 64,
   parameter int unsigned DEADTIME   = 4
) (
   input  logic                                          clk_in,
   input  logic                                          rst_n,
   input  logic [7:0]                                    brightness,
   input  logic                                          swap_req,
   output logic                                          swap_ack,
   output logic                                          frame_done,
   output logic [$clog2(PANEL_W)-1:0]                    rd_col,
   output logic [$clog2(SCAN_ROWS)-1:0]                  rd_row,
   output logic [((COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1)-1:0] rd_plane,
   output logic                                          rd_buf,
   input  logic [5:0]                                    rd_data,
   output logic [$clog2(SCAN_ROWS)-1:0]                  row_sel,
   output logic                                          R1,
   output logic                                          G1,
   output logic                                          B1,
   output logic                                          R2,
   output logic                                          G2,
   output logic                                          B2,
   output logic                                          CLK,
   output logic                                          LAT,
   output logic                                          OE
);

   localparam int unsigned CW = $clog2(PANEL_W);
   localparam int unsigned RW = $clog2(SCAN_ROWS);
   localparam int unsigned PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
   localparam int unsigned SW = $clog2(2 * CLK_DIV);

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_slot;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [RW-1:0] r_row_sel;
   logic [PW-1:0] r_plane;
   logic          r_buf;
   logic [5:0]    r_rgb;
   logic          r_swap_ack;
   logic          r_frame_done;

   logic          w_slot_last;
   logic          w_col_last;
   logic          w_plane_last;
   logic          w_row_last;
   logic          w_oe_n;
   logic          w_plane_done;
   logic          w_load;
   logic          w_run;

`ifdef HUB75_DEADTIME_EN
   localparam int unsigned DTW = $clog2(DEADTIME) + 1;
   logic [DTW-1:0] r_settle;
`else
   logic           w_unused_deadtime;
   assign w_unused_deadtime = |DEADTIME;
`endif

   assign w_slot_last  = (r_slot == SW'(2 * CLK_DIV - 1));
   assign w_col_last   = (r_col == CW'(PANEL_W - 1));
   assign w_plane_last = (r_plane == PW'(COLOR_BITS - 1));
   assign w_row_last   = (r_row == RW'(SCAN_ROWS - 1));
   assign w_load       = (r_state == S_LATCH);
   assign w_run        = (r_state == S_DISPLAY);

   hub75_bcm_timer #(
      .BASE_UNIT  (BASE_UNIT),
      .COLOR_BITS (COLOR_BITS),
      .PW         (PW)
   ) u_timer (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .i_load       (w_load),
      .i_run        (w_run),
      .i_plane      (r_plane),
      .i_brightness (brightness),
      .o_oe_n       (w_oe_n),
      .o_plane_done (w_plane_done)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= S_SHIFT;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      CLK    = 1'b0;
      LAT    = 1'b0;
      OE     = 1'b1;
      case (r_state)
         S_SHIFT: begin
            CLK = (r_slot >= SW'(CLK_DIV));
            if (w_slot_last && w_col_last) w_next = S_LATCH;
         end
         S_LATCH: begin
            LAT = 1'b1;
`ifdef HUB75_DEADTIME_EN
            w_next = S_SETTLE;
`else
            w_next = S_DISPLAY;
`endif
         end
         S_SETTLE: begin
`ifdef HUB75_DEADTIME_EN
            if (r_settle == DTW'(DEADTIME - 1)) w_next = S_DISPLAY;
`else
            w_next = S_DISPLAY;
`endif
         end
         S_DISPLAY: begin
            OE = w_oe_n;
            if (w_plane_done) w_next = S_SHIFT;
         end
         default: w_next = S_SHIFT;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_slot       <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_row_sel    <= '0;
         r_plane      <= '0;
         r_buf        <= 1'b0;
         r_rgb        <= '0;
         r_swap_ack   <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef HUB75_DEADTIME_EN
         r_settle     <= '0;
`endif
      end else begin
         r_swap_ack   <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_SHIFT: begin
               if (w_slot_last) begin
                  r_slot <= '0;
                  r_col  <= r_col + CW'(1);  // wraps to 0 after the last column
               end else begin
                  r_slot <= r_slot + SW'(1);
               end
               // Read data arrives one cycle after the slot-0 address.
               if (r_slot == SW'(1)) r_rgb <= rd_data;
            end
            S_LATCH: begin
               r_row_sel <= r_row;
`ifdef HUB75_DEADTIME_EN
               r_settle  <= '0;
`endif
            end
            S_SETTLE: begin
`ifdef HUB75_DEADTIME_EN
               r_settle <= r_settle + DTW'(1);
`endif
            end
            S_DISPLAY: begin
               if (w_plane_done) begin
                  if (w_plane_last) begin
                     r_plane <= '0;
                     r_row   <= r_row + RW'(1);
                     if (w_row_last) begin
                        r_frame_done <= 1'b1;
                        if (swap_req) begin
                           r_buf      <= ~r_buf;
                           r_swap_ack <= 1'b1;
                        end
                     end
                  end else begin
                     r_plane <= r_plane + PW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_col     = r_col;
   assign rd_row     = r_row;
   assign rd_plane   = r_plane;
   assign rd_buf     = r_buf;
   assign row_sel    = r_row_sel;
   assign swap_ack   = r_swap_ack;
   assign frame_done = r_frame_done;
   assign R1         = r_rgb[IDX_R1];
   assign G1         = r_rgb[IDX_G1];
   assign B1         = r_rgb[IDX_B1];
   assign R2         = r_rgb[IDX_R2];
   assign G2         = r_rgb[IDX_G2];
   assign B2         = r_rgb[IDX_B2];

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// ---------------------------------------------------------------------------
// tb_hub75_bcm_scanner
// Scoreboard bench: the stimulus process pushes expected shifted pixels,
// per-plane display figures and per-frame swap results into queues; a
// negedge monitor pops and compares as the DUT presents CLK rises, LAT
// pulses and frame_done pulses.
// ---------------------------------------------------------------------------
module tb_hub75_bcm_scanner;

   localparam int unsigned PANEL_W    = 4;
   localparam int unsigned SCAN_ROWS  = 2;
   localparam int unsigned COLOR_BITS = 2;
   localparam int unsigned CLK_DIV    = 2;
   localparam int unsigned BASE_UNIT  = 8;
   localparam int unsigned SHIFT_CYC  = PANEL_W * 2 * CLK_DIV;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] brightness = 8'd0;
   logic       swap_req = 1'b0;
   logic       swap_ack, frame_done;
   logic [1:0] rd_col;
   logic       rd_row;
   logic       rd_plane;
   logic       rd_buf;
   logic [5:0] rd_data;
   logic       row_sel;
   logic       R1, G1, B1, R2, G2, B2;
   logic       CLK, LAT, OE;

   always #5 clk_in = ~clk_in;

   hub75_bcm_scanner #(
      .PANEL_W    (PANEL_W),
      .SCAN_ROWS  (SCAN_ROWS),
      .COLOR_BITS (COLOR_BITS),
      .CLK_DIV    (CLK_DIV),
      .BASE_UNIT  (BASE_UNIT),
      .DEADTIME   (4)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .brightness (brightness),
      .swap_req   (swap_req),
      .swap_ack   (swap_ack),
      .frame_done (frame_done),
      .rd_col     (rd_col),
      .rd_row     (rd_row),
      .rd_plane   (rd_plane),
      .rd_buf     (rd_buf),
      .rd_data    (rd_data),
      .row_sel    (row_sel),
      .R1 (R1), .G1 (G1), .B1 (B1), .R2 (R2), .G2 (G2), .B2 (B2),
      .CLK        (CLK),
      .LAT        (LAT),
      .OE         (OE)
   );

   // External pixel store, 1-cycle read latency.
   logic [5:0] mem [2][SCAN_ROWS][PANEL_W][COLOR_BITS];
   always @(posedge clk_in) rd_data <= mem[rd_buf][rd_row][rd_col][rd_plane];

   typedef struct { logic bsel; logic [5:0] rgb; } col_exp_t;
   typedef struct { int unsigned row; int unsigned on; int unsigned len; } plane_exp_t;
   typedef struct { logic ack; logic bsel; } frame_exp_t;

   col_exp_t   q_col[$];
   plane_exp_t q_plane[$];
   frame_exp_t q_frame[$];

   int unsigned checks   = 0;
   int unsigned failures = 0;
   bit          mon_en   = 1'b0;
   logic        exp_buf  = 1'b0;
   int unsigned frame_len;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // ---------------- monitor ----------------
   int unsigned cyc = 0, last_fd = 0, lat_cyc = 0, oe_low = 0, clk_rises = 0;
   bit          fd_anchor = 1'b1, win_valid = 1'b0, oe_gap = 1'b0;
   logic        prev_clk = 1'b0;
   plane_exp_t  cur;

   always @(negedge clk_in) begin
      col_exp_t   ce;
      frame_exp_t fe;
      int unsigned off;
      if (!mon_en) begin
         prev_clk  = 1'b0;
         win_valid = 1'b0;
         fd_anchor = 1'b1;
      end else begin
         cyc++;
         if (fd_anchor) begin
            last_fd   = cyc;
            fd_anchor = 1'b0;
         end
         if (CLK && !prev_clk) begin
            clk_rises++;
            if (q_col.size() == 0) chk("col_queue_underflow", 1, 0);
            else begin
               ce = q_col.pop_front();
               chk("rgb_at_clk_rise", {R1, G1, B1, R2, G2, B2}, ce.rgb);
               chk("rd_buf_in_shift", rd_buf, ce.bsel);
               chk("oe_in_shift", OE, 1);
            end
         end
         prev_clk = CLK;
         if (LAT) begin
            chk("oe_at_lat", OE, 1);
            if (win_valid) begin
               chk("plane_period", cyc - lat_cyc, cur.len + SHIFT_CYC + 1);
               chk("oe_low_cycles", oe_low, cur.on);
               chk("oe_low_contiguous", oe_gap, 0);
               chk("clk_rises_per_shift", clk_rises, PANEL_W);
            end
            if (q_plane.size() == 0) begin
               chk("plane_queue_underflow", 1, 0);
               win_valid = 1'b0;
            end else begin
               cur       = q_plane.pop_front();
               win_valid = 1'b1;
            end
            lat_cyc   = cyc;
            oe_low    = 0;
            oe_gap    = 1'b0;
            clk_rises = 0;
         end else if (win_valid) begin
            off = cyc - lat_cyc;
            if (off == 1) chk("row_sel", row_sel, cur.row);
            if (!OE) begin
               if (off != oe_low + 1) oe_gap = 1'b1;
               oe_low++;
            end
         end
         if (frame_done) begin
            if (q_frame.size() == 0) chk("frame_queue_underflow", 1, 0);
            else begin
               fe = q_frame.pop_front();
               chk("swap_ack", swap_ack, fe.ack);
               chk("rd_buf_after_frame", rd_buf, fe.bsel);
            end
            chk("frame_period", cyc - last_fd, frame_len);
            last_fd = cyc;
         end else if (swap_ack) begin
            chk("swap_ack_without_frame_done", swap_ack, 0);
         end
      end
   end

   // ---------------- stimulus + reference model ----------------
   // Entry and exit: 1 time unit after the edge that starts the first shift
   // cycle of a frame. mode: 0 random, 1 brightness 127, 2 brightness 0.
   task automatic run_frame(input int unsigned mode, input bit rand_mem, input bit req);
      int unsigned len, on, b, k, j;
      if (rand_mem)
         for (int bf = 0; bf < 2; bf++)
            for (int r = 0; r < SCAN_ROWS; r++)
               for (int c = 0; c < PANEL_W; c++)
                  for (int p = 0; p < COLOR_BITS; p++)
                     mem[bf][r][c][p] = 6'($urandom);
      for (int r = 0; r < SCAN_ROWS; r++)
         for (int p = 0; p < COLOR_BITS; p++)
            for (int c = 0; c < PANEL_W; c++)
               q_col.push_back('{exp_buf, mem[exp_buf][r][c][p]});
      q_frame.push_back('{req, exp_buf ^ req});
      for (int r = 0; r < SCAN_ROWS; r++)
         for (int p = 0; p < COLOR_BITS; p++) begin
            len = BASE_UNIT << p;
            case (mode)
               1: b = 127;
               2: b = 0;
               default: begin
                  case ($urandom_range(3, 0))
                     0: b = 0;
                     1: b = 255;
                     2: b = 127;
                     default: b = $urandom_range(255, 0);
                  endcase
               end
            endcase
            on = (len * (b + 1)) / 256;
            q_plane.push_back('{r, on, len});
            k = $urandom_range(SHIFT_CYC - 1, 0);
            tick(k);
            brightness = 8'(b);
            tick(SHIFT_CYC - k);
            if (req && r == 0 && p == 0) swap_req = 1'b1;
            tick(1);
            // change brightness mid-display; must not affect this plane
            j = $urandom_range(len - 1, 0);
            tick(j);
            brightness = 8'($urandom);
            tick(len - j);
         end
      exp_buf  = exp_buf ^ req;
      swap_req = 1'b0;
   endtask

   initial begin
      int unsigned n;
      frame_len = 0;
      for (int p = 0; p < COLOR_BITS; p++) frame_len += SHIFT_CYC + 1 + (BASE_UNIT << p);
      frame_len *= SCAN_ROWS;

      for (int bf = 0; bf < 2; bf++)
         for (int r = 0; r < SCAN_ROWS; r++)
            for (int c = 0; c < PANEL_W; c++)
               for (int p = 0; p < COLOR_BITS; p++)
                  mem[bf][r][c][p] = (bf == 0 && c == 2) ? 6'b101010 : 6'b000000;

      tick(3);
      chk("reset_oe", OE, 1);
      chk("reset_lat", LAT, 0);
      chk("reset_clk", CLK, 0);
      chk("reset_rgb", {R1, G1, B1, R2, G2, B2}, 0);
      chk("reset_row_sel", row_sel, 0);
      chk("reset_rd_buf", rd_buf, 0);
      chk("reset_swap_ack", swap_ack, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_rd_addr", {rd_col, rd_row, rd_plane}, 0);

      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_frame(1, 1'b0, 1'b0);
      run_frame(2, 1'b1, 1'b1);
      run_frame(0, 1'b1, 1'b0);
      run_frame(0, 1'b1, 1'b1);
      run_frame(0, 1'b1, 1'b1);
      run_frame(0, 1'b1, 1'b0);
      tick(1);
      mon_en = 1'b0;
      q_col.delete();
      q_plane.delete();
      q_frame.delete();

      // Reset while a row-1 plane is being displayed.
      brightness = 8'd255;
      n = 0;
      while (!(OE === 1'b0 && row_sel === 1'b1) && n < 400) begin
         tick(1);
         n++;
      end
      chk("oe_low_before_reset", OE, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_oe", OE, 1);
      chk("async_reset_clk", CLK, 0);
      chk("async_reset_row_sel", row_sel, 0);
      chk("async_reset_lat", LAT, 0);
      chk("async_reset_rd_buf", rd_buf, 0);
      chk("async_reset_rgb", {R1, G1, B1, R2, G2, B2}, 0);
      tick(3);
      rst_n = 1'b1;
      chk("restart_rd_col", rd_col, 0);
      chk("restart_rd_row", rd_row, 0);
      chk("restart_rd_plane", rd_plane, 0);
      exp_buf = 1'b0;
      mon_en  = 1'b1;
      run_frame(0, 1'b1, 1'b1);
      run_frame(1, 1'b1, 1'b0);
      run_frame(0, 1'b1, 1'b1);
      run_frame(2, 1'b1, 1'b0);
      tick(1);
      mon_en = 1'b0;
      chk("col_queue_drained", q_col.size(), 0);
      chk("plane_queue_drained", q_plane.size(), 0);
      chk("frame_queue_drained", q_frame.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
